// File: rtl/reg_file_pkg.sv
// Shared defaults and named configuration-entry addresses for the configurable register file.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_CFG    = 4;

    // Config-entry addresses as seen by the datapath consumers of Cfg_Regs
    localparam int CFG_ALU_OP = 0;
    localparam int CFG_ALU_B  = 1;
    localparam int CFG_UART   = 2;
    localparam int CFG_DIV    = 3;

    localparam logic [DEF_NUM_CFG*DEF_DATA_WIDTH-1:0] DEF_CFG_RST_VAL =
        {8'h20, 8'h81, 8'h00, 8'h00};

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WRITE,
        ACC_READ,
        ACC_CONFLICT
    } access_e;

endpackage

// File: rtl/reg_file_rd_pipe.sv
// Read-return delay line: carries the read valid flag and data LATENCY cycles,
// holding the last delivered data between valid pulses.
module reg_file_rd_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    vld;
    logic [DATA_WIDTH-1:0] dat [LATENCY];

    // Data stages only load alongside a valid flag so the output never moves without a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/reg_file_cfg.sv
// Parametrised single-port register file with per-entry reset values, read-only masking,
// pipelined reads with a valid pulse, access-error pulses and a packed config export.
module reg_file_cfg
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 16,
    parameter int NUM_CFG    = DEF_NUM_CFG,
    parameter int RD_LATENCY = 1,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_RST_VAL = DEF_CFG_RST_VAL,
    parameter logic [DEPTH-1:0]              RO_MASK     = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WrEn,
    input  logic                          RdEn,
    input  logic [ADDR_WIDTH-1:0]         Address,
    input  logic [DATA_WIDTH-1:0]         WrData,
    output logic [DATA_WIDTH-1:0]         RdData,
    output logic                          RdData_Valid,
    output logic                          Err,
    output logic [NUM_CFG*DATA_WIDTH-1:0] Cfg_Regs
);

    localparam int MEM_BITS = DEPTH * DATA_WIDTH;
    localparam int SPAN     = 2 ** ADDR_WIDTH;

    // Reset image and RO mask widened so unimplemented entries read as zero / writable-but-absent
    localparam logic [MEM_BITS-1:0] RST_IMAGE = MEM_BITS'(CFG_RST_VAL);
    localparam logic [SPAN-1:0]     RO_FULL   = SPAN'(RO_MASK);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    access_e               access;
    logic                  in_range;
    logic                  wr_ok;
    logic                  rd_accept;
    logic                  err_next;
    logic                  err_q;

    assign in_range = ({1'b0, Address} < (ADDR_WIDTH+1)'(DEPTH));

    always_comb begin
        access = ACC_IDLE;
        case ({WrEn, RdEn})
            2'b10:   access = ACC_WRITE;
            2'b01:   access = ACC_READ;
            2'b11:   access = ACC_CONFLICT;
            default: access = ACC_IDLE;
        endcase
    end

    assign wr_ok     = (access == ACC_WRITE) && in_range && !RO_FULL[Address];
    assign rd_accept = (access == ACC_READ);
    assign err_next  = (access == ACC_CONFLICT)
                     || ((access == ACC_WRITE) && !wr_ok)
                     || ((access == ACC_READ) && !in_range);

    // Address match mux; out-of-range addresses match nothing and yield zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_WIDTH'(i)) begin
                rd_word = mem[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Address == ADDR_WIDTH'(i)) begin
                    mem[i] <= WrData;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
        end
    end

    assign Err = err_q;

    reg_file_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (CLK),
        .rst_n     (RST),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (RdData_Valid),
        .out_data  (RdData)
    );

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign Cfg_Regs[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_reg_file_cfg.sv
// Scoreboard bench: one stimulus stream drives a latency-1 full-depth instance and a
// latency-2, depth-12, entry-3-read-only instance, each checked against its own array model.
module tb_reg_file_cfg;
    import reg_file_pkg::*;

    localparam int N = 2;
    localparam logic [31:0] RST_CFG = 32'h2081_0000;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] addr;
    logic [7:0] wr_data;
    logic [7:0]  rd_data [N];
    logic        valid   [N];
    logic        err     [N];
    logic [31:0] cfg     [N];

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [N][16];
    logic [7:0] last_rd   [N];
    rd_exp_t    rd_q      [N][$];
    int         err_q     [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_cfg #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .NUM_CFG(4), .RD_LATENCY(1),
        .CFG_RST_VAL(32'h2081_0000), .RO_MASK(16'h0000)
    ) dut_a (
        .CLK(clk), .RST(rst_n), .WrEn(wr_en), .RdEn(rd_en), .Address(addr), .WrData(wr_data),
        .RdData(rd_data[0]), .RdData_Valid(valid[0]), .Err(err[0]), .Cfg_Regs(cfg[0])
    );

    reg_file_cfg #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_CFG(4), .RD_LATENCY(2),
        .CFG_RST_VAL(32'h2081_0000), .RO_MASK(12'h008)
    ) dut_b (
        .CLK(clk), .RST(rst_n), .WrEn(wr_en), .RdEn(rd_en), .Address(addr), .WrData(wr_data),
        .RdData(rd_data[1]), .RdData_Valid(valid[1]), .Err(err[1]), .Cfg_Regs(cfg[1])
    );

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int depth_of(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic bit ro_of(int k, int a);
        return (k == 1) && (a == CFG_DIV);
    endfunction

    function automatic logic [31:0] model_cfg(int k);
        return {model_mem[k][3], model_mem[k][2], model_mem[k][1], model_mem[k][0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        logic [31:0] rv;
        rv = RST_CFG;
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 16; a++) begin
                model_mem[k][a] = (a < 4) ? rv[a*8 +: 8] : 8'h00;
            end
            last_rd[k] = 8'h00;
            rd_q[k].delete();
            err_q[k].delete();
        end
    endtask

    // Called just after a rising edge; returns just after the edge that captured the access
    task automatic applyStimulus(input bit wr, input bit rd, input int a, input logic [7:0] d);
        rd_exp_t item;
        bit      in_rng;
        wr_en   = wr;
        rd_en   = rd;
        addr    = 4'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            in_rng = (a < depth_of(k));
            if (wr && rd) begin
                err_q[k].push_back(cyc);
            end else if (wr) begin
                if (in_rng && !ro_of(k, a)) model_mem[k][a] = d;
                else err_q[k].push_back(cyc);
            end else if (rd) begin
                item.data = in_rng ? model_mem[k][a] : 8'h00;
                item.due  = cyc + lat_of(k) - 1;
                rd_q[k].push_back(item);
                if (!in_rng) err_q[k].push_back(cyc);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < N; k++) begin
            check("reset_rddata", 32'(rd_data[k]), 32'h0);
            check("reset_valid", 32'(valid[k]), 32'h0);
            check("reset_err", 32'(err[k]), 32'h0);
            check("reset_cfg", cfg[k], RST_CFG);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input int k);
        rd_exp_t it;
        int      due;
        if (valid[k]) begin
            if (rd_q[k].size() == 0) begin
                check("spurious_valid", 32'(valid[k]), 32'h0);
            end else begin
                it = rd_q[k].pop_front();
                check("rd_data", 32'(rd_data[k]), 32'(it.data));
                check("rd_latency", 32'(cyc), 32'(it.due));
                last_rd[k] = it.data;
            end
        end else begin
            check("rd_hold", 32'(rd_data[k]), 32'(last_rd[k]));
            if (rd_q[k].size() > 0 && rd_q[k][0].due <= cyc) begin
                check("missing_valid", 32'(valid[k]), 32'h1);
                void'(rd_q[k].pop_front());
            end
        end
        if (err[k]) begin
            if (err_q[k].size() == 0) begin
                check("spurious_err", 32'(err[k]), 32'h0);
            end else begin
                due = err_q[k].pop_front();
                check("err_cycle", 32'(cyc), 32'(due));
            end
        end else if (err_q[k].size() > 0 && err_q[k][0] <= cyc) begin
            check("missing_err", 32'(err[k]), 32'h1);
            void'(err_q[k].pop_front());
        end
        check("cfg_regs", cfg[k], model_cfg(k));
    endtask

    // Monitor: decoupled from stimulus, compares whatever the DUTs present each cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N; k++) checkOutput(k);
        end
    end

    initial begin
        int r;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        wr_data = '0;
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        applyStimulus(1'b0, 1'b1, 5, 8'h00);
        idle(2);
        applyStimulus(1'b1, 1'b0, 7, 8'hA5);
        applyStimulus(1'b0, 1'b1, 7, 8'h00);
        idle(3);
        applyStimulus(1'b0, 1'b1, CFG_ALU_OP, 8'h00);
        applyStimulus(1'b0, 1'b1, CFG_ALU_B, 8'h00);
        applyStimulus(1'b0, 1'b1, CFG_UART, 8'h00);
        applyStimulus(1'b0, 1'b1, CFG_DIV, 8'h00);
        idle(3);
        applyStimulus(1'b1, 1'b1, CFG_UART, 8'hFF);
        idle(2);
        applyStimulus(1'b1, 1'b0, CFG_DIV, 8'h55);
        applyStimulus(1'b0, 1'b1, CFG_DIV, 8'h00);
        applyStimulus(1'b1, 1'b0, 13, 8'h5A);
        applyStimulus(1'b0, 1'b1, 13, 8'h00);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            applyStimulus(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8,
                          $urandom_range(0, 15), 8'($urandom));
        end
        idle(3);

        applyStimulus(1'b0, 1'b1, 9, 8'h00);
        do_reset();
        idle(3);
        for (int a = 0; a < 16; a++) applyStimulus(1'b0, 1'b1, a, 8'h00);
        idle(4);

        for (int k = 0; k < N; k++) begin
            check("rd_q_drained", 32'(rd_q[k].size()), 32'h0);
            check("err_q_drained", 32'(err_q[k].size()), 32'h0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
